// File: rtl/orde_entry_ctrl.sv
// Entry allocation/retirement controller for one ordering-engine block.
// Allocates in issue order, accepts responses in any order, retires in issue order.
module orde_entry_ctrl #(
    parameter int unsigned NUM_PER_BLOCK = 32,
    localparam int unsigned IW = $clog2(NUM_PER_BLOCK)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          alloc_req_i,
    output logic          alloc_gnt_o,
    output logic [IW-1:0] alloc_idx_o,
    input  logic          resp_valid_i,
    input  logic [IW-1:0] resp_idx_i,
    output logic          empty_idx_valid_o,
    output logic [IW-1:0] empty_idx_o,
    output logic          oldest_idx_valid_o,
    output logic [IW-1:0] oldest_idx_o,
    output logic          oldest_idx_next_valid_o,
    output logic [IW-1:0] oldest_idx_next_o,
    output logic          pop_idx_valid_o,
    output logic [IW-1:0] pop_idx_o,
    output logic [IW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          err_o
);

    localparam int unsigned CW = IW + 1;

    logic [IW-1:0]            head_q, head_d;
    logic [IW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [NUM_PER_BLOCK-1:0] alloc_vec_q, alloc_vec_d;
    logic [NUM_PER_BLOCK-1:0] done_vec_q, done_vec_d;
    logic                     err_q, err_d;

    logic          full;
    logic          empty;
    logic          gnt;
    logic          pop;
    logic          resp_ok;
    logic [IW-1:0] head_inc;
    logic [IW-1:0] tail_inc;

    assign full     = (count_q == CW'(NUM_PER_BLOCK));
    assign empty    = (count_q == '0);
    // Grant uses the registered full, so a slot freed by a pop is granted next cycle.
    assign gnt      = alloc_req_i & ~full & ~rst_i;
    assign pop      = ~empty & done_vec_q[head_q];
    assign resp_ok  = alloc_vec_q[resp_idx_i] & ~done_vec_q[resp_idx_i];
    assign head_inc = head_q + IW'(1);
    assign tail_inc = tail_q + IW'(1);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        alloc_vec_d = alloc_vec_q;
        done_vec_d  = done_vec_q;
        err_d       = err_q;

        if (pop) begin
            alloc_vec_d[head_q] = 1'b0;
            done_vec_d[head_q]  = 1'b0;
            head_d              = head_inc;
        end

        if (gnt) begin
            alloc_vec_d[tail_q] = 1'b1;
            done_vec_d[tail_q]  = 1'b0;
            tail_d              = tail_inc;
        end

        // Responses check registered state only: a same-cycle allocation is not yet live.
        if (resp_valid_i && !rst_i) begin
            if (resp_ok) begin
                done_vec_d[resp_idx_i] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        count_d = count_q + CW'(gnt) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            alloc_vec_q <= '0;
            done_vec_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            alloc_vec_q <= alloc_vec_d;
            done_vec_q  <= done_vec_d;
            err_q       <= err_d;
        end
    end

    assign alloc_gnt_o             = gnt;
    assign alloc_idx_o             = tail_q;
    assign empty_idx_valid_o       = ~full;
    assign empty_idx_o             = tail_q;
    assign oldest_idx_valid_o      = ~empty;
    assign oldest_idx_o            = head_q;
    assign oldest_idx_next_valid_o = (count_d != '0);
    assign oldest_idx_next_o       = pop ? head_inc : head_q;
    assign pop_idx_valid_o         = pop;
    assign pop_idx_o               = head_q;
    assign count_o                 = count_q;
    assign full_o                  = full;
    assign empty_o                 = empty;
    assign err_o                   = err_q;

endmodule

// File: tb/tb_orde_entry_ctrl.sv
// Directed self-checking bench for orde_entry_ctrl with hand-computed expectations.
module tb_orde_entry_ctrl;

    localparam int unsigned N  = 32;
    localparam int unsigned IW = 5;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_idx;
    logic          resp_valid;
    logic [IW-1:0] resp_idx;
    logic          empty_idx_valid;
    logic [IW-1:0] empty_idx;
    logic          oldest_idx_valid;
    logic [IW-1:0] oldest_idx;
    logic          oldest_idx_next_valid;
    logic [IW-1:0] oldest_idx_next;
    logic          pop_idx_valid;
    logic [IW-1:0] pop_idx;
    logic [IW:0]   count;
    logic          full;
    logic          empty;
    logic          err;

    int n_total = 0;
    int n_bad   = 0;

    orde_entry_ctrl #(
        .NUM_PER_BLOCK(N)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .alloc_req_i             (alloc_req),
        .alloc_gnt_o             (alloc_gnt),
        .alloc_idx_o             (alloc_idx),
        .resp_valid_i            (resp_valid),
        .resp_idx_i              (resp_idx),
        .empty_idx_valid_o       (empty_idx_valid),
        .empty_idx_o             (empty_idx),
        .oldest_idx_valid_o      (oldest_idx_valid),
        .oldest_idx_o            (oldest_idx),
        .oldest_idx_next_valid_o (oldest_idx_next_valid),
        .oldest_idx_next_o       (oldest_idx_next),
        .pop_idx_valid_o         (pop_idx_valid),
        .pop_idx_o               (pop_idx),
        .count_o                 (count),
        .full_o                  (full),
        .empty_o                 (empty),
        .err_o                   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        alloc_req  = 1'b0;
        resp_valid = 1'b0;
        resp_idx   = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic resp_cycle(input int idx);
        alloc_req  = 1'b0;
        resp_valid = 1'b1;
        resp_idx   = IW'(idx);
        tick();
        resp_valid = 1'b0;
    endtask

    int m_head;
    int idx;

    initial begin
        rst        = 1'b1;
        alloc_req  = 1'b1;
        resp_valid = 1'b0;
        resp_idx   = '0;

        // Reset held two cycles with a pending request
        tick();
        chk("rst_gnt0", alloc_gnt, 0);
        tick();
        chk("rst_gnt1", alloc_gnt, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_eidx_v", empty_idx_valid, 1);
        chk("rst_eidx", empty_idx, 0);
        chk("rst_old_v", oldest_idx_valid, 0);
        chk("rst_old", oldest_idx, 0);
        chk("rst_nxt_v", oldest_idx_next_valid, 0);
        chk("rst_nxt", oldest_idx_next, 0);
        chk("rst_pop_v", pop_idx_valid, 0);
        chk("rst_pop", pop_idx, 0);
        chk("rst_err", err, 0);

        // Fill to full with back-to-back requests
        rst       = 1'b0;
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            settle();
            chk("fill_gnt", alloc_gnt, 1);
            chk("fill_idx", alloc_idx, i);
            tick();
        end
        settle();
        chk("fill_full", full, 1);
        chk("fill_count", count, 32);
        chk("fill_gnt33", alloc_gnt, 0);
        chk("fill_eidx_v", empty_idx_valid, 0);
        chk("fill_eidx", empty_idx, 0);
        chk("fill_old_v", oldest_idx_valid, 1);
        tick();
        chk("fill_count33", count, 32);

        // Grant and pop at full: freed slot only grantable next cycle
        resp_cycle(0);
        alloc_req = 1'b1;
        settle();
        chk("gp_pop_v", pop_idx_valid, 1);
        chk("gp_pop", pop_idx, 0);
        chk("gp_gnt_n", alloc_gnt, 0);
        chk("gp_nxt", oldest_idx_next, 1);
        chk("gp_nxt_v", oldest_idx_next_valid, 1);
        tick();
        chk("gp_gnt_n1", alloc_gnt, 1);
        chk("gp_aidx", alloc_idx, 0);
        chk("gp_old", oldest_idx, 1);
        chk("gp_pop_v1", pop_idx_valid, 0);
        tick();
        alloc_req = 1'b0;
        settle();
        chk("gp_count", count, 32);
        chk("gp_full", full, 1);
        chk("gp_eidx", empty_idx, 1);

        // Out-of-order responses, in-order retirement
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ooo_aidx", alloc_idx, i);
            tick();
        end
        alloc_req = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            resp_valid = 1'b1;
            resp_idx   = IW'(i);
            settle();
            chk("ooo_nopop", pop_idx_valid, 0);
            tick();
        end
        resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ooo_pop_v", pop_idx_valid, 1);
            chk("ooo_pop", pop_idx, i);
            chk("ooo_old", oldest_idx, i);
            tick();
        end
        chk("ooo_old3", oldest_idx, 3);
        chk("ooo_empty", empty, 1);
        chk("ooo_pop_end", pop_idx_valid, 0);
        chk("ooo_err", err, 0);

        // Wrap-around with allocate/respond/retire triples
        do_reset();
        m_head = 0;
        for (int i = 0; i < 40; i++) begin
            idx        = i % 32;
            alloc_req  = 1'b1;
            resp_valid = 1'b0;
            settle();
            chk("wr_gnt", alloc_gnt, 1);
            chk("wr_aidx", alloc_idx, idx);
            chk("wr_old", oldest_idx, m_head);
            chk("wr_nxt_a", oldest_idx_next, m_head);
            tick();
            alloc_req  = 1'b0;
            resp_valid = 1'b1;
            resp_idx   = IW'(idx);
            settle();
            chk("wr_nopop", pop_idx_valid, 0);
            chk("wr_nxt_b", oldest_idx_next, m_head);
            tick();
            resp_valid = 1'b0;
            settle();
            chk("wr_pop_v", pop_idx_valid, 1);
            chk("wr_pop", pop_idx, idx);
            m_head = (m_head + 1) % 32;
            chk("wr_nxt_c", oldest_idx_next, m_head);
            chk("wr_nxt_v", oldest_idx_next_valid, 0);
            tick();
        end
        chk("wr_old_end", oldest_idx, 8);
        chk("wr_empty", empty, 1);
        chk("wr_err", err, 0);

        // Response to unallocated entry
        do_reset();
        resp_cycle(5);
        chk("e_unalloc", err, 1);
        chk("e_count", count, 0);
        chk("e_old_v", oldest_idx_valid, 0);
        chk("e_pop_v", pop_idx_valid, 0);
        chk("e_eidx", empty_idx, 0);
        tick();
        chk("e_sticky", err, 1);
        do_reset();
        chk("e_rst_clr", err, 0);

        // Duplicate response behind a not-done head
        alloc_req = 1'b1;
        tick();
        tick();
        resp_cycle(1);
        chk("dup_first", err, 0);
        resp_cycle(1);
        chk("dup_err", err, 1);
        chk("dup_count", count, 2);
        chk("dup_pop_v", pop_idx_valid, 0);

        // Response to the entry being allocated in the same cycle
        do_reset();
        alloc_req  = 1'b1;
        resp_valid = 1'b1;
        resp_idx   = '0;
        tick();
        alloc_req  = 1'b0;
        resp_valid = 1'b0;
        chk("same_err", err, 1);
        chk("same_count", count, 1);
        chk("same_pop_v", pop_idx_valid, 0);

        // Late response after mid-operation reset
        do_reset();
        alloc_req = 1'b1;
        tick();
        do_reset();
        chk("late_cnt", count, 0);
        resp_cycle(0);
        chk("late_err", err, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
